// File: rtl/jtag_axi_arb_if.sv
// Shared-manager arbitration bundle: requester side, the AXI handshake
// strobes seen on the shared port, and grant/timeout status.
interface jtag_axi_arb_if #(
  parameter int NUM_REQ = 2
);
  localparam int SW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req_i;
  logic [NUM_REQ-1:0] wr_i;
  logic [NUM_REQ-1:0] gnt_o;
  logic [SW-1:0]      sel_o;
  logic               aw_hs_i;
  logic               ar_hs_i;
  logic               w_last_hs_i;
  logic               b_hs_i;
  logic               r_last_hs_i;
  logic               busy_o;
  logic               tout_o;
  logic [SW-1:0]      tout_idx_o;

  modport master (
    output req_i, wr_i,
    output aw_hs_i, ar_hs_i, w_last_hs_i,
    output b_hs_i, r_last_hs_i,
    input  gnt_o, sel_o, busy_o,
    input  tout_o, tout_idx_o
  );

  modport slave (
    input  req_i, wr_i,
    input  aw_hs_i, ar_hs_i, w_last_hs_i,
    input  b_hs_i, r_last_hs_i,
    output gnt_o, sel_o, busy_o,
    output tout_o, tout_idx_o
  );
endinterface

// File: rtl/jtag_axi_arb.sv
// Round-robin arbiter granting one AXI manager port to NUM_REQ requesters,
// tracking each transaction through ADDR/DATA/RESP with a timeout abort.
module jtag_axi_arb #(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic           clk,
  input logic           rstn,
  jtag_axi_arb_if.slave bus
);
  localparam int SW = $clog2(NUM_REQ);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  logic [1:0]         state;
  logic [NUM_REQ-1:0] gnt;
  logic [SW-1:0]      sel;
  logic [SW-1:0]      last_w;
  logic [SW-1:0]      win;
  logic [SW-1:0]      tout_idx;
  logic               wr_q;
  logic               wl_seen;
  logic               tout;
  logic [15:0]        cnt;
  logic               done;
  logic               expire;
  logic               found;
  int                 idx;

  assign done = (state == RESP) &&
                (wr_q ? bus.b_hs_i : bus.r_last_hs_i);

  // a completing handshake in the last allowed cycle beats the abort
  assign expire = (state != IDLE) &&
                  (cnt == TO_LAST) && !done;

  always_comb begin
    win   = last_w;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_w) + k) % NUM_REQ;
      if (!found && bus.req_i[idx]) begin
        win   = SW'(idx);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      gnt      <= '0;
      sel      <= '0;
      last_w   <= SW'(NUM_REQ - 1);
      wr_q     <= 1'b0;
      wl_seen  <= 1'b0;
      tout     <= 1'b0;
      tout_idx <= '0;
      cnt      <= '0;
    end else begin
      tout <= 1'b0;
      if (state != IDLE && cnt != 16'hFFFF)
        cnt <= cnt + 16'd1;
      if (state == IDLE) begin
        if (found) begin
          state   <= ADDR;
          gnt     <= NUM_REQ'(1) << win;
          sel     <= win;
          wr_q    <= bus.wr_i[win];
          wl_seen <= 1'b0;
          cnt     <= '0;
        end
      end else if (done || expire) begin
        state  <= IDLE;
        gnt    <= '0;
        last_w <= sel;
        if (expire) begin
          tout     <= 1'b1;
          tout_idx <= sel;
        end
      end else begin
        unique case (state)
          ADDR: begin
            if (wr_q) begin
              if (bus.aw_hs_i)
                state <= (bus.w_last_hs_i || wl_seen)
                         ? RESP : DATA;
              else if (bus.w_last_hs_i)
                wl_seen <= 1'b1;
            end else if (bus.ar_hs_i) begin
              state <= RESP;
            end
          end
          DATA: begin
            if (bus.w_last_hs_i)
              state <= RESP;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.gnt_o      = gnt;
  assign bus.sel_o      = sel;
  assign bus.busy_o     = |gnt;
  assign bus.tout_o     = tout;
  assign bus.tout_idx_o = tout_idx;
endmodule

// File: tb/tb_jtag_axi_arb.sv
// Scoreboard bench: driver predicts winner/duration/timeout per transaction,
// monitor checks them as grants rise and fall.
module tb_jtag_axi_arb;
  localparam int N  = 3;
  localparam int T  = 8;
  localparam int SW = $clog2(N);

  typedef struct {
    int win;
    int dur;
    bit tout;
    int rc;
    bit abort;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  jtag_axi_arb_if #(.NUM_REQ(N)) bus ();

  jtag_axi_arb #(
    .NUM_REQ    (N),
    .TIMEOUT_CYC(T)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   last_w   = N - 1;
  int   mdl_tidx = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp_v);
    end
  endtask

  function automatic int rr_pick(input int reqv);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last_w + k) % N;
      if (reqv[i]) return i;
    end
    return -1;
  endfunction

  task automatic idle_noise();
    bus.req_i       = '0;
    bus.wr_i        = N'($urandom);
    bus.aw_hs_i     = 1'($urandom_range(0, 1));
    bus.ar_hs_i     = 1'($urandom_range(0, 1));
    bus.w_last_hs_i = 1'($urandom_range(0, 1));
    bus.b_hs_i      = 1'($urandom_range(0, 1));
    bus.r_last_hs_i = 1'($urandom_range(0, 1));
  endtask

  task automatic clear_in();
    bus.req_i       = '0;
    bus.wr_i        = '0;
    bus.aw_hs_i     = 1'b0;
    bus.ar_hs_i     = 1'b0;
    bus.w_last_hs_i = 1'b0;
    bus.b_hs_i      = 1'b0;
    bus.r_last_hs_i = 1'b0;
  endtask

  // mode 0: completes at random offset, 1: never completes, 2: completes
  // exactly in the timeout cycle. Offsets count granted cycles from 0.
  task automatic txn(input int reqv, input int wrv, input int mode,
                     input int a_in, input int w_in, input int r_in);
    int   win, a, w, r, base, dur;
    bit   wr;
    exp_t e;
    win = rr_pick(reqv);
    wr  = wrv[win];
    a   = (a_in >= 0) ? a_in : $urandom_range(0, 3);
    w   = (w_in >= 0) ? w_in : $urandom_range(0, 4);
    base = wr ? ((a > w ? a : w) + 1) : (a + 1);
    if (r_in >= 0)      r = r_in;
    else if (mode == 1) r = -1;
    else if (mode == 2) r = T - 1;
    else                r = $urandom_range(T - 1, base);
    dur = (r < 0) ? T : r + 1;
    bus.req_i = N'(reqv);
    bus.wr_i  = N'(wrv);
    e.win = win; e.dur = dur; e.tout = (r < 0);
    e.rc = cyc; e.abort = 1'b0;
    sbq.push_back(e);
    last_w = win;
    for (int k = 0; k < dur; k++) begin
      @(negedge clk);
      bus.req_i       = N'($urandom);
      bus.wr_i        = N'($urandom);
      bus.aw_hs_i     = wr ? 1'(k == a) : 1'($urandom_range(0, 1));
      bus.w_last_hs_i = wr ? 1'(k == w) : 1'($urandom_range(0, 1));
      bus.b_hs_i      = wr ? 1'(k == r) : 1'($urandom_range(0, 1));
      bus.ar_hs_i     = wr ? 1'($urandom_range(0, 1)) : 1'(k == a);
      bus.r_last_hs_i = wr ? 1'($urandom_range(0, 1)) : 1'(k == r);
    end
    @(negedge clk);
    idle_noise();
  endtask

  task automatic reset_mid_data();
    exp_t e;
    clear_in();
    bus.req_i = N'(1);
    bus.wr_i  = N'(1);
    e.win = rr_pick(1); e.dur = 0; e.tout = 1'b0;
    e.rc = cyc; e.abort = 1'b1;
    sbq.push_back(e);
    @(negedge clk);
    bus.req_i   = '0;
    bus.aw_hs_i = 1'b1;
    @(negedge clk);
    bus.aw_hs_i = 1'b0;
    #1 rstn = 1'b0;
    #1;
    chk("rst_gnt", bus.gnt_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_tout", bus.tout_o, 0);
    last_w = N - 1;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin : monitor
    exp_t cur;
    bit   have = 1'b0;
    bit   pg   = 1'b0;
    bit   g;
    int   dur  = 0;
    forever begin
      @(negedge clk);
      if (!rstn) mdl_tidx = 0;
      g = |bus.gnt_o;
      if (g && !pg) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_grant gnt=%0d expected none",
                   bus.gnt_o);
        end else begin
          cur  = sbq.pop_front();
          have = 1'b1;
          chk("gnt", bus.gnt_o, 1 << cur.win);
          chk("sel", bus.sel_o, cur.win);
          chk("busy_hi", bus.busy_o, 1);
          chk("grant_latency", cyc, cur.rc + 1);
          dur = 1;
        end
      end else if (g) begin
        dur++;
      end else if (pg && have) begin
        have = 1'b0;
        chk("busy_lo", bus.busy_o, 0);
        if (!cur.abort) begin
          chk("grant_dur", dur, cur.dur);
          chk("tout", bus.tout_o, cur.tout);
          if (cur.tout) mdl_tidx = cur.win;
          chk("tout_idx", bus.tout_idx_o, mdl_tidx);
        end
      end else if (bus.tout_o) begin
        checks++;
        failures++;
        $display("FAIL stray_tout tout=1 expected 0");
      end
      pg = g;
    end
  end

  initial begin : driver
    clear_in();
    #2;
    chk("reset_gnt", bus.gnt_o, 0);
    chk("reset_sel", bus.sel_o, 0);
    chk("reset_busy", bus.busy_o, 0);
    chk("reset_tout", bus.tout_o, 0);
    chk("reset_tidx", bus.tout_idx_o, 0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    txn(3, 0, 0, 0, 0, 1);
    txn(3, 0, 0, 0, 0, 1);
    txn(1, 1, 0, 0, 0, 1);
    txn(1, 1, 0, 2, 0, 3);
    txn(2, 0, 1, -1, -1, -1);
    txn(1, 1, 2, 1, 2, -1);
    reset_mid_data();
    txn(1, 0, 0, 0, 0, 2);
    for (int i = 0; i < 60; i++) begin
      txn($urandom_range(1, (1 << N) - 1),
          $urandom_range(0, (1 << N) - 1),
          $urandom_range(0, 2), -1, -1, -1);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        idle_noise();
      end
    end
    clear_in();
    repeat (4) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    chk("final_busy", bus.busy_o, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
